rr_arbiter8: RTL and testbench

Round-robin arbiter that shares one downstream resource between eight requesters. The core is a rotating 8-to-3 priority encoder that produces a one-hot grant plus a 3-bit encoded index, gated by an enable. A grant holds until the owner releases it, drops its request, or reaches a hold limit. The arbiter sits in front of any single-port resource (bus, shared register file, output channel) and is the sequencing companion to the plain `encoder` block.

---
 rtl/rr_arbiter8_pkg.sv | 21 ++
 rtl/rr_arbiter8_if.sv | 25 ++
 rtl/rr_arbiter8_pick.sv | 31 +++
 rtl/rr_arbiter8.sv | 123 ++++++++++++
 tb/tb_rr_arbiter8.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter8_pkg.sv
// Shared types and constants for the eight-way round-robin arbiter.
package arb_pkg;

    // Two-state arbiter control: waiting for requests, or serving one owner.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    // Expands an encoded requester index into its one-hot grant vector.
    function automatic logic [N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage : arb_pkg

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_arbiter8_if;
    import arb_pkg::*;

    logic             enable;
    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    // Requester side: drives requests, enable and release.
    modport master (
        output enable, req, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    // Arbiter side: consumes requests and produces the registered grant.
    modport slave (
        input  enable, req, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );

endinterface : rr_arbiter8_if

// File: rtl/rr_arbiter8_pick.sv
// Rotating 8-to-3 priority encoder: the first set request bit at or after
// ptr (wrapping modulo 8) wins. Purely combinational.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset back to ptr so the closest hit is written last.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            // Addition wraps naturally at 3 bits, giving the modulo-8 rotation.
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with hold limit. The winner keeps the
// grant until it signals done, drops its request, enable falls, or it has
// held for MAX_HOLD cycles. One idle cycle always separates two grants, and
// the pointer moves just past the last owner so every requester gets a turn.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter8_if.slave  bus
);

    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state_q,     state_d;
    logic [IDX_W-1:0]  ptr_q,       ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic [N-1:0]      gnt_q,       gnt_d;
    logic [IDX_W-1:0]  gnt_idx_q,   gnt_idx_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic              timeout_q,   timeout_d;

    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;

    logic              rel_done;
    logic              rel_noreq;
    logic              rel_disable;
    logic              rel_limit;
    logic              release_now;

    rr_pick u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Release causes for the current owner, listed in priority order.
    always_comb begin
        rel_done    = bus.done;
        rel_noreq   = ~bus.req[gnt_idx_q];
        rel_disable = ~bus.enable;
        rel_limit   = (hold_cnt_q == HOLD_LAST);
        release_now = rel_done | rel_noreq | rel_disable | rel_limit;
    end

    // Next-state logic for the FSM, pointer, hold counter and output registers.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.enable && pick_found) begin
                    state_d     = GRANT;
                    gnt_d       = idx_to_onehot(pick_idx);
                    gnt_idx_d   = pick_idx;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end else begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                end
            end

            GRANT: begin
                if (release_now) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    ptr_d       = gnt_idx_q + IDX_W'(1);
                    // Only a pure hold-limit revocation is reported as a timeout.
                    timeout_d   = rel_limit & ~rel_done & ~rel_noreq & ~rel_disable;
                end else begin
                    hold_cnt_d  = hold_cnt_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;

endmodule : rr_arbiter8

// File: tb/tb_rr_arbiter8.sv
// Directed and randomized bench for rr_arbiter8 against a behavioural model.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst;

    rr_arbiter8_if bus ();

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: who owns the resource, for how many cycles so far,
    // and where the next search starts.
    bit m_busy;
    int m_owner;
    int m_cycles_held;
    int m_next_start;
    bit m_timeout;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Applies one clock edge to the model using the inputs present at that edge.
    task automatic model_edge();
        if (rst) begin
            m_busy = 0; m_owner = 0; m_cycles_held = 0; m_next_start = 0; m_timeout = 0;
        end else if (!m_busy) begin
            m_timeout = 0;
            if (bus.enable && bus.req != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (bus.req[(m_next_start + k) % 8]) begin
                        m_owner = (m_next_start + k) % 8;
                        break;
                    end
                end
                m_busy = 1;
                m_cycles_held = 1;
            end
        end else begin
            if (bus.done || !bus.req[m_owner] || !bus.enable) begin
                m_busy = 0; m_timeout = 0;
            end else if (m_cycles_held == MAX_HOLD) begin
                m_busy = 0; m_timeout = 1;
            end else begin
                m_cycles_held++;
            end
            if (!m_busy) m_next_start = (m_owner + 1) % 8;
        end
    endtask

    // One clock: advance the model at the edge, then compare 1 time unit later.
    task automatic step();
        logic [7:0] exp_gnt;
        @(posedge clk);
        model_edge();
        #1;
        exp_gnt = m_busy ? (8'h01 << m_owner) : 8'h00;
        check("gnt",       bus.gnt,                 exp_gnt);
        check("gnt_valid", {7'd0, bus.gnt_valid},   {7'd0, m_busy});
        check("gnt_idx",   {5'd0, bus.gnt_idx},     8'(m_owner));
        check("timeout",   {7'd0, bus.timeout},     {7'd0, m_timeout});
    endtask

    initial begin
        rst = 1'b1; bus.enable = 1'b1; bus.req = 8'hFF; bus.done = 1'b0;
        m_busy = 0; m_owner = 0; m_cycles_held = 0; m_next_start = 0; m_timeout = 0;

        // Reset held for two cycles with all requests asserted.
        step(); step();
        check("reset_gnt",       bus.gnt,               8'h00);
        check("reset_gnt_valid", {7'd0, bus.gnt_valid}, 8'h00);
        check("reset_timeout",   {7'd0, bus.timeout},   8'h00);
        rst = 1'b0;
        step();
        check("first_gnt", bus.gnt,              8'h01);
        check("first_idx", {5'd0, bus.gnt_idx},  8'h00);

        // Rotation: done on the second grant cycle, grants walk 0..7 then wrap to 0.
        for (int n = 0; n < 9; n++) begin
            check("rot_idx", {5'd0, bus.gnt_idx}, 8'(n % 8));
            check("rot_gnt", bus.gnt, 8'h01 << (n % 8));
            bus.done = 1'b0; step();
            bus.done = 1'b1; step();
            check("rot_idle", {7'd0, bus.gnt_valid}, 8'h00);
            bus.done = 1'b0; step();
        end

        // Enable low: current owner released, then nothing granted for 5 cycles.
        bus.enable = 1'b0; bus.req = 8'h10;
        step();
        check("en_drop_timeout", {7'd0, bus.timeout}, 8'h00);
        for (int n = 0; n < 5; n++) begin
            step();
            check("en_low_gnt", bus.gnt, 8'h00);
        end
        bus.enable = 1'b1;
        step();
        check("en_gnt", bus.gnt, 8'h10);
        check("en_idx", {5'd0, bus.gnt_idx}, 8'h04);
        bus.enable = 1'b0;
        step();
        check("en_mid_gnt",     bus.gnt,              8'h00);
        check("en_mid_timeout", {7'd0, bus.timeout},  8'h00);

        // Timeout: sole requester 2 holds for exactly MAX_HOLD cycles.
        bus.enable = 1'b1; bus.req = 8'h04;
        step();
        for (int n = 0; n < MAX_HOLD; n++) begin
            check("to_hold_gnt", bus.gnt, 8'h04);
            if (n < MAX_HOLD - 1) step();
        end
        step();
        check("to_gnt",   bus.gnt,             8'h00);
        check("to_pulse", {7'd0, bus.timeout}, 8'h01);
        step();
        check("to_regrant",     {5'd0, bus.gnt_idx}, 8'h02);
        check("to_pulse_clear", {7'd0, bus.timeout}, 8'h00);

        // done coinciding with the hold limit: released without timeout.
        for (int n = 0; n < MAX_HOLD - 1; n++) step();
        bus.done = 1'b1;
        step();
        check("done_limit_gnt",     bus.gnt,             8'h00);
        check("done_limit_timeout", {7'd0, bus.timeout}, 8'h00);
        bus.done = 1'b0;

        // Owner 7 drops its request while requester 0 still asks: 0 is next.
        bus.req = 8'h81;
        step();
        check("own7_gnt", bus.gnt, 8'h80);
        bus.req = 8'h01;
        step();
        check("own7_rel", bus.gnt, 8'h00);
        step();
        check("own7_next", {5'd0, bus.gnt_idx}, 8'h00);

        // Reset mid-grant clears everything and restarts the pointer at 0.
        bus.req = 8'h00;
        step();
        bus.req = 8'h20;
        step();
        check("rst_mid_pre", bus.gnt, 8'h20);
        rst = 1'b1;
        step();
        check("rst_mid_gnt",   bus.gnt,               8'h00);
        check("rst_mid_valid", {7'd0, bus.gnt_valid}, 8'h00);
        rst = 1'b0; bus.req = 8'hFF;
        step();
        check("rst_mid_next", bus.gnt, 8'h01);

        // Randomized traffic checked cycle by cycle against the model.
        for (int n = 0; n < 600; n++) begin
            bus.req    = 8'($urandom);
            bus.done   = ($urandom_range(0, 5) == 0);
            bus.enable = ($urandom_range(0, 9) != 0);
            rst        = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 2) == 0 && m_busy) bus.req[m_owner] = 1'b1;
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rr_arbiter8
